// File: rtl/score_digit_sequencer.sv
// Pong score keeper: counts point strobes, detects game over and time-multiplexes
// "P1 : P2" (or the winner code) onto a 4-bit digit bus for the dot-matrix controller.
module score_digit_sequencer #(
    parameter int unsigned DWELL_CYCLES = 25_000_000,
    parameter int unsigned CNT_W        = 25,
    parameter int unsigned WIN_SCORE    = 9
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       p1_point_i,
    input  logic       p2_point_i,
    input  logic       clear_i,
    output logic [3:0] digit_o,
    output logic [1:0] slot_o,
    output logic [3:0] p1_score_o,
    output logic [3:0] p2_score_o,
    output logic       game_over_o,
    output logic [1:0] winner_o
);

    // State encoding doubles as the slot number driven on slot_o.
    localparam logic [1:0] S_P1   = 2'd0;
    localparam logic [1:0] S_SEP  = 2'd1;
    localparam logic [1:0] S_P2   = 2'd2;
    localparam logic [1:0] S_SEP2 = 2'd3;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [3:0]       WinCode = 4'(WIN_SCORE);
    localparam logic [3:0]       SepCode = 4'hA;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             p1_prev_q, p2_prev_q;
    logic [3:0]       p1_score_q, p1_score_d;
    logic [3:0]       p2_score_q, p2_score_d;
    logic             game_over_q, game_over_d;
    logic [1:0]       winner_q, winner_d;
    logic [3:0]       digit_q, digit_d;

    logic       p1_rise, p2_rise;
    logic [3:0] p1_next, p2_next;
    logic       p1_hit, p2_hit;
    logic [3:0] win_digit;

    assign p1_rise = p1_point_i & ~p1_prev_q;
    assign p2_rise = p2_point_i & ~p2_prev_q;
    assign p1_next = p1_score_q + {3'b000, p1_rise};
    assign p2_next = p2_score_q + {3'b000, p2_rise};
    assign p1_hit  = (p1_next == WinCode);
    assign p2_hit  = (p2_next == WinCode);

    // Scores and game-over; clear beats any point, and a finished game freezes scores.
    always_comb begin
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        game_over_d = game_over_q;
        winner_d    = winner_q;
        if (clear_i) begin
            p1_score_d  = 4'd0;
            p2_score_d  = 4'd0;
            game_over_d = 1'b0;
            winner_d    = 2'd0;
        end else if (!game_over_q) begin
            p1_score_d  = p1_next;
            p2_score_d  = p2_next;
            game_over_d = p1_hit | p2_hit;
            winner_d    = {p2_hit, p1_hit};
        end
    end

    // Dwell counter and display slot sequencing.
    always_comb begin
        cnt_d   = cnt_q;
        state_d = state_q;
        if (clear_i) begin
            cnt_d   = '0;
            state_d = S_P1;
        end else if (cnt_q == CntLast) begin
            cnt_d = '0;
            case (state_q)
                S_P1:    state_d = S_SEP;
                S_SEP:   state_d = S_P2;
                S_P2:    state_d = S_SEP2;
                default: state_d = S_P1;
            endcase
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // A tie has no single winner to show, so it renders as 0.
    assign win_digit = (winner_d == 2'd3) ? 4'd0 : {2'b00, winner_d};

    always_comb begin
        digit_d = SepCode;
        case (state_d)
            S_P1:    digit_d = game_over_d ? win_digit : p1_score_d;
            S_P2:    digit_d = game_over_d ? win_digit : p2_score_d;
            default: digit_d = SepCode;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_P1;
            cnt_q       <= '0;
            p1_prev_q   <= 1'b0;
            p2_prev_q   <= 1'b0;
            p1_score_q  <= 4'd0;
            p2_score_q  <= 4'd0;
            game_over_q <= 1'b0;
            winner_q    <= 2'd0;
            digit_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p1_prev_q   <= p1_point_i;
            p2_prev_q   <= p2_point_i;
            p1_score_q  <= p1_score_d;
            p2_score_q  <= p2_score_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
            digit_q     <= digit_d;
        end
    end

    assign digit_o     = digit_q;
    assign slot_o      = state_q;
    assign p1_score_o  = p1_score_q;
    assign p2_score_o  = p2_score_q;
    assign game_over_o = game_over_q;
    assign winner_o    = winner_q;

endmodule

// File: tb/tb_score_digit_sequencer.sv
// Bench for score_digit_sequencer: directed scenarios plus random point/clear traffic,
// checked every cycle against a behavioural score/display model.
module tb_score_digit_sequencer;

    localparam int unsigned Dwell = 4;
    localparam int unsigned Win   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       p1 = 1'b0, p2 = 1'b0, clr = 1'b0;
    logic [3:0] digit, p1_score, p2_score;
    logic [1:0] slot, winner;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    // Model state: scores, outcome, and edges elapsed since the last restart.
    int m_s1, m_s2, m_win, m_cyc;
    bit m_go, m_prev1, m_prev2;

    score_digit_sequencer #(
        .DWELL_CYCLES(Dwell),
        .CNT_W       (3),
        .WIN_SCORE   (Win)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .p1_point_i (p1),
        .p2_point_i (p2),
        .clear_i    (clr),
        .digit_o    (digit),
        .slot_o     (slot),
        .p1_score_o (p1_score),
        .p2_score_o (p2_score),
        .game_over_o(game_over),
        .winner_o   (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_slot();
        return (m_cyc / Dwell) % 4;
    endfunction

    function automatic int exp_digit();
        int s;
        int wc;
        s  = exp_slot();
        wc = (m_win == 3) ? 0 : m_win;
        if (s == 1 || s == 3) return 10;
        if (s == 0) return m_go ? wc : m_s1;
        return m_go ? wc : m_s2;
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_win = 0; m_cyc = 0;
        m_go = 1'b0; m_prev1 = 1'b0; m_prev2 = 1'b0;
    endtask

    task automatic model_step(input bit a, input bit b, input bit c);
        bit r1, r2;
        r1 = a & ~m_prev1;
        r2 = b & ~m_prev2;
        m_prev1 = a;
        m_prev2 = b;
        if (c) begin
            m_s1 = 0; m_s2 = 0; m_win = 0; m_go = 1'b0; m_cyc = 0;
        end else begin
            if (!m_go) begin
                m_s1 += int'(r1);
                m_s2 += int'(r2);
                if (m_s1 == Win || m_s2 == Win) begin
                    m_go  = 1'b1;
                    m_win = ((m_s2 == Win) ? 2 : 0) + ((m_s1 == Win) ? 1 : 0);
                end
            end
            m_cyc++;
        end
    endtask

    task automatic check_all();
        check("slot", 32'(slot), exp_slot());
        check("digit", 32'(digit), exp_digit());
        check("p1_score", 32'(p1_score), m_s1);
        check("p2_score", 32'(p2_score), m_s2);
        check("game_over", 32'(game_over), 32'(m_go));
        check("winner", 32'(winner), m_win);
    endtask

    // Called just after an active edge: drive inputs, take one edge, then compare.
    task automatic cycle(input bit a, input bit b, input bit c);
        p1  = a;
        p2  = b;
        clr = c;
        @(posedge clk);
        model_step(a, b, c);
        #1;
        check_all();
    endtask

    initial begin
        bit found;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Idle display sequence 0 : 0 :
        repeat (20) cycle(1'b0, 1'b0, 1'b0);

        // Held point counts once
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        check("hold_p1_once", 32'(p1_score), 1);
        cycle(1'b0, 1'b0, 1'b0);

        // Simultaneous rises from a fresh game
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b0);
        check("simul_p1", 32'(p1_score), 1);
        check("simul_p2", 32'(p2_score), 1);
        cycle(1'b0, 1'b0, 1'b0);

        // P2 wins; further rises are ignored
        repeat (3) begin
            cycle(1'b0, 1'b1, 1'b0);
            cycle(1'b0, 1'b0, 1'b0);
        end
        check("win_p2_score", 32'(p2_score), Win);
        check("win_game_over", 32'(game_over), 1);
        check("win_winner", 32'(winner), 2);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("frozen_p2", 32'(p2_score), Win);
        repeat (16) cycle(1'b0, 1'b0, 1'b0);

        // Clear beats a same-edge rise and restarts the dwell
        cycle(1'b1, 1'b0, 1'b1);
        check("clear_p1", 32'(p1_score), 0);
        check("clear_go", 32'(game_over), 0);
        check("clear_slot", 32'(slot), 0);
        repeat (8) cycle(1'b0, 1'b0, 1'b0);

        // Async reset mid-slot in S_P2 with nonzero scores
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (exp_slot() == 2 && (m_cyc % Dwell) == 1) found = 1'b1;
            else cycle(1'b0, 1'b0, 1'b0);
        end
        check("reach_sp2", 32'(found), 1);
        check("pre_rst_slot", 32'(slot), 2);
        #2 rst = 1'b1;
        #1;
        check("async_rst_digit", 32'(digit), 0);
        check("async_rst_slot", 32'(slot), 0);
        check("async_rst_p1", 32'(p1_score), 0);
        check("async_rst_p2", 32'(p2_score), 0);
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
        repeat (12) cycle(1'b0, 1'b0, 1'b0);

        // Random point and clear traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 29) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete (checks %0d)", checks);
        $fatal(1, "timeout");
    end

endmodule
